// File: rtl/morv_mem_arbiter.sv
// Two-port memory arbiter (fetch/load-store) onto a single downstream bus with a wait timeout.
// Optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN; otherwise port 1 has fixed priority.
module morv_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_write,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_gnt,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_write,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_gnt,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_req,
    output logic [31:0] address,
    output logic [31:0] wdata,
    output logic        write,
    output logic [3:0]  wstrb,
    input  logic [31:0] rdata,
    input  logic        ready
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  BUSY      = 1'b1;
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    logic [0:0]  state;
    logic        owner;
    logic [15:0] wait_cnt;
    logic        win1;
    logic        any_req;
    logic        expire;
    logic        done;

    assign any_req = p0_req | p1_req;
    assign expire  = (state == BUSY) && (wait_cnt == TIMEOUT_L);
    assign done    = (state == BUSY) && (ready || expire);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_served;

    // On contention, grant whichever port was not served last.
    always_comb begin
        win1 = 1'b0;
        if (p0_req && p1_req) begin
            win1 = ~last_served;
        end else begin
            win1 = p1_req;
        end
    end

    // Pointer remembers the most recent grant; reset value means "port 1 last".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if ((state == IDLE) && any_req) begin
            last_served <= win1;
        end else begin
            last_served <= last_served;
        end
    end
`else
    // Fixed priority: port 1 always wins.
    always_comb begin
        win1 = p1_req;
    end
`endif

    // Transaction FSM; downstream fields are latched once at grant and frozen while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            wait_cnt <= 16'd0;
            mem_req  <= 1'b0;
            address  <= 32'd0;
            wdata    <= 32'd0;
            write    <= 1'b0;
            wstrb    <= 4'd0;
            p0_gnt   <= 1'b0;
            p1_gnt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= BUSY;
                        owner    <= win1;
                        wait_cnt <= 16'd0;
                        mem_req  <= 1'b1;
                        address  <= win1 ? p1_addr  : p0_addr;
                        wdata    <= win1 ? p1_wdata : p0_wdata;
                        write    <= win1 ? p1_write : p0_write;
                        wstrb    <= win1 ? p1_wstrb : p0_wstrb;
                        p0_gnt   <= ~win1;
                        p1_gnt   <= win1;
                    end else begin
                        mem_req  <= 1'b0;
                        p0_gnt   <= 1'b0;
                        p1_gnt   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state    <= IDLE;
                        wait_cnt <= 16'd0;
                        mem_req  <= 1'b0;
                        p0_gnt   <= 1'b0;
                        p1_gnt   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    p0_gnt  <= 1'b0;
                    p1_gnt  <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulses are combinational so data returns in the same cycle as ready.
    always_comb begin
        p0_ready = done && !owner;
        p1_ready = done && owner;
        p0_err   = p0_ready && expire && !ready;
        p1_err   = p1_ready && expire && !ready;
        p0_rdata = (p0_ready && ready) ? rdata : 32'd0;
        p1_rdata = (p1_ready && ready) ? rdata : 32'd0;
    end

endmodule
